// File: rtl/byte_serial_adder.sv
// ----------------------------------------------------------------------------
// byte_serial_adder
//
// Multi-cycle WIDTH-bit adder that reuses a single combinational 8-bit adder
// slice. Operands arrive on a valid/ready input port. The block then sums one
// byte per clock, starting with the least significant byte. The carry is held
// in a flip-flop between bytes. The full sum, the carry-out and the signed
// overflow flag are presented on a valid/ready output port.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   operands a, b, cin are valid this cycle
//   in_ready   block can accept operands (high only while idle)
//   a, b       WIDTH-bit operands
//   cin        carry into byte 0
//   out_valid  s, cout, ovf are valid (high only while a result is held)
//   out_ready  consumer accepts the result
//   s          a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow of the addition
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// adder
//
// Combinational 8-bit adder slice.
//
// Ports
//   a, b   8-bit operands
//   cin    carry in
//   s      8-bit sum
//   cout   carry out of bit 7
// ----------------------------------------------------------------------------
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

module byte_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Operands and the sum are held as byte arrays so the running byte
    // index selects a slice directly.
    logic [NBYTES-1:0][7:0] a_q;
    logic [NBYTES-1:0][7:0] b_q;
    logic [NBYTES-1:0][7:0] s_q;
    logic                   carry_q;
    logic [IDXW-1:0]        idx;
    logic                   cout_q;
    logic                   ovf_q;

    logic [7:0]             slice_s;
    logic                   slice_cout;
    logic                   last_byte;
    logic                   sign_a;
    logic                   sign_b;

    adder u_adder (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign last_byte = (idx == LAST_IDX);
    assign sign_a    = a_q[NBYTES-1][7];
    assign sign_b    = b_q[NBYTES-1][7];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk every byte in RUN, and hold the
    // result in DONE until the consumer takes it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_byte) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state alone, so there is no
    // combinational path from any input to any output.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. Operands are captured only on the accept edge. During RUN
    // one sum byte is written per clock and the carry is fed back into the
    // slice. The final byte also produces cout and ovf. idx stops at the last
    // byte so it never indexes past the operand arrays.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        s_q     <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                RUN: begin
                    s_q[idx] <= slice_s;
                    carry_q  <= slice_cout;
                    if (last_byte) begin
                        cout_q <= slice_cout;
                        ovf_q  <= (sign_a == sign_b) && (slice_s[7] != sign_a);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
